// File: rtl/miller_decoder_param.sv
// rtl/miller_decoder_param.sv - Miller (M=1) baseband decoder with drift-tracking bit timing
//
// Samples the oversampled tag-to-reader line, locks bit-cell timing to the line
// edges, checks Miller coding rules and packs decoded bits into words.
//
// Ports:
//   clk            system clock, one line sample per cycle
//   rst            synchronous active-high reset (wins over in_enable)
//   in_enable      low aborts any frame and holds the decoder idle
//   in_data        raw Miller line, asynchronous to clk
//   out_bit        decoded bit, qualified by out_valid
//   out_valid      one-cycle strobe per decoded bit
//   out_word       packed word, first received bit in the MSB
//   out_word_valid one-cycle strobe when DATA_W bits are collected
//   out_count      bits decoded in the current frame, saturating
//   out_eof        one-cycle strobe at end of frame
//   out_err        one-cycle strobe on coding or timing violation
//   out_busy       high while a frame is being decoded
module miller_decoder_param #(
    parameter int HALF_BIT = 8,
    parameter int TOL      = 2,
    parameter int SYNC     = 2,
    parameter int DATA_W   = 8,
    parameter int CW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_enable,
    input  logic              in_data,
    output logic              out_bit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_word,
    output logic              out_word_valid,
    output logic [CW-1:0]     out_count,
    output logic              out_eof,
    output logic              out_err,
    output logic              out_busy
);

    localparam int CELL  = 2 * HALF_BIT;
    localparam int CNT_W = $clog2(CELL);
    localparam int BC_W  = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CELL - 1);
    localparam logic [CNT_W-1:0] C_EARLY  = CNT_W'(CELL - TOL);
    localparam logic [CNT_W-1:0] C_LATE   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] C_MID_LO = CNT_W'(HALF_BIT - TOL);
    localparam logic [CNT_W-1:0] C_MID_HI = CNT_W'(HALF_BIT + TOL);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_W - 1);

    typedef enum logic {IDLE_S, RUN_S} state_t;

    state_t              state_q, state_n;
    logic [SYNC-1:0]     sync_q;
    logic                line_q;
    logic                edge_q;
    logic [CNT_W-1:0]    c_q, c_n;
    logic                mid_q, mid_n;
    logic                bnd_q, bnd_n;
    logic                empty_q, empty_n;  // previous cell carried no edge
    logic                last_q, last_n;    // value of the previously emitted bit
    logic [DATA_W-1:0]   shreg_q, shreg_n;
    logic [BC_W-1:0]     bcnt_q, bcnt_n;
    logic [DATA_W-1:0]   word_n;
    logic [CW-1:0]       count_n;
    logic                bit_n, valid_n, wvalid_n, eof_n, err_n;
    logic                early, cell_end, viol;
    logic [DATA_W-1:0]   shifted;

    // Synchroniser and previous-sample register track the line continuously so
    // that a reset never manufactures an edge out of a stale sample.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC-2:0], in_data};
        line_q <= sync_q[SYNC-1];
    end

    assign out_busy = (state_q == RUN_S);

    always_comb begin
        state_n  = state_q;
        c_n      = c_q;
        mid_n    = mid_q;
        bnd_n    = bnd_q;
        empty_n  = empty_q;
        last_n   = last_q;
        shreg_n  = shreg_q;
        bcnt_n   = bcnt_q;
        word_n   = out_word;
        count_n  = out_count;
        bit_n    = 1'b0;
        valid_n  = 1'b0;
        wvalid_n = 1'b0;
        eof_n    = 1'b0;
        err_n    = 1'b0;
        early    = 1'b0;
        cell_end = 1'b0;
        viol     = 1'b0;
        shifted  = {shreg_q[DATA_W-2:0], mid_q};

        case (state_q)
            IDLE_S: begin
                if (edge_q) begin
                    state_n = RUN_S;
                    c_n     = '0;
                    mid_n   = 1'b0;
                    bnd_n   = 1'b0;
                    empty_n = 1'b0;
                    last_n  = 1'b0;
                    shreg_n = '0;
                    bcnt_n  = '0;
                    count_n = '0;
                end
            end
            RUN_S: begin
                c_n = c_q + 1'b1;
                if (edge_q) begin
                    if (c_q >= C_EARLY) begin
                        early = 1'b1;
                    end else if (c_q != '0 && c_q <= C_LATE) begin
                        // Line runs slow: re-centre on this edge, the cell it
                        // closes was already emitted at the counter wrap.
                        c_n   = '0;
                        bnd_n = 1'b1;
                    end else if (c_q >= C_MID_LO && c_q <= C_MID_HI) begin
                        if (mid_q) viol = 1'b1;
                        else       mid_n = 1'b1;
                    end else begin
                        viol = 1'b1;
                    end
                end

                // An edge on the last count is an early boundary, so the bit and
                // the boundary are handled together here.
                cell_end = early || (c_q == C_LAST);
                if (cell_end) begin
                    c_n = '0;
                    if (bnd_q && (mid_q || last_q)) begin
                        // boundary edge is only legal between two zeros
                        viol = 1'b1;
                    end else if (!mid_q && !bnd_q && empty_q) begin
                        eof_n   = 1'b1;
                        state_n = IDLE_S;
                    end else begin
                        empty_n = !mid_q && !bnd_q;
                        last_n  = mid_q;
                        bit_n   = mid_q;
                        valid_n = 1'b1;
                        shreg_n = shifted;
                        if (out_count != '1) count_n = out_count + 1'b1;
                        if (bcnt_q == BC_LAST) begin
                            word_n   = shifted;
                            wvalid_n = 1'b1;
                            bcnt_n   = '0;
                        end else begin
                            bcnt_n = bcnt_q + 1'b1;
                        end
                    end
                    mid_n = 1'b0;
                    bnd_n = early;
                end

                if (viol) begin
                    err_n   = 1'b1;
                    valid_n = 1'b0;
                    state_n = IDLE_S;
                end
            end
            default: state_n = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !in_enable) begin
            state_q        <= IDLE_S;
            edge_q         <= 1'b0;
            c_q            <= '0;
            mid_q          <= 1'b0;
            bnd_q          <= 1'b0;
            empty_q        <= 1'b0;
            last_q         <= 1'b0;
            shreg_q        <= '0;
            bcnt_q         <= '0;
            out_word       <= '0;
            out_count      <= '0;
            out_bit        <= 1'b0;
            out_valid      <= 1'b0;
            out_word_valid <= 1'b0;
            out_eof        <= 1'b0;
            out_err        <= 1'b0;
        end else begin
            state_q        <= state_n;
            edge_q         <= sync_q[SYNC-1] ^ line_q;
            c_q            <= c_n;
            mid_q          <= mid_n;
            bnd_q          <= bnd_n;
            empty_q        <= empty_n;
            last_q         <= last_n;
            shreg_q        <= shreg_n;
            bcnt_q         <= bcnt_n;
            out_word       <= word_n;
            out_count      <= count_n;
            out_bit        <= bit_n;
            out_valid      <= valid_n;
            out_word_valid <= wvalid_n;
            out_eof        <= eof_n;
            out_err        <= err_n;
        end
    end

endmodule

// File: tb/tb_miller_decoder_param.sv
// tb/tb_miller_decoder_param.sv - self-checking bench for miller_decoder_param
module tb_miller_decoder_param;

    localparam int HALF_BIT = 8;
    localparam int TOL      = 2;
    localparam int SYNC     = 2;
    localparam int DATA_W   = 8;
    localparam int CW       = 16;
    localparam int CELL     = 2 * HALF_BIT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_enable = 1'b1;
    logic              in_data = 1'b0;
    logic              out_bit;
    logic              out_valid;
    logic [DATA_W-1:0] out_word;
    logic              out_word_valid;
    logic [CW-1:0]     out_count;
    logic              out_eof;
    logic              out_err;
    logic              out_busy;

    always #5 clk = ~clk;

    miller_decoder_param #(
        .HALF_BIT(HALF_BIT), .TOL(TOL), .SYNC(SYNC), .DATA_W(DATA_W), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_enable(in_enable), .in_data(in_data),
        .out_bit(out_bit), .out_valid(out_valid), .out_word(out_word),
        .out_word_valid(out_word_valid), .out_count(out_count), .out_eof(out_eof),
        .out_err(out_err), .out_busy(out_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit                exp_bits[$];
    logic [DATA_W-1:0] exp_words[$];
    int                exp_len;
    bit                exp_eof = 1'b0;
    bit                exp_err = 1'b0;
    int                model_cnt = 0;
    bit                done = 1'b0;
    int                last_valid_cyc = 0;
    int                err_cyc = 0;
    logic [DATA_W-1:0] last_word = '0;
    int                last_eof_cnt = 0;
    int                force_db[$];

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard: every strobe must match the head of the expected streams.
    always @(negedge clk) begin
        bit                eb;
        logic [DATA_W-1:0] ew;
        cyc++;
        if (out_valid) begin
            if (exp_bits.size() == 0) begin
                chk(1'b0, "unexpected_bit", out_bit, -1);
            end else begin
                eb = exp_bits.pop_front();
                chk(out_bit == eb, "bit", out_bit, eb);
                model_cnt++;
                chk(out_count == model_cnt, "count", out_count, model_cnt);
            end
            last_valid_cyc = cyc;
        end
        if (out_word_valid) begin
            if (exp_words.size() == 0) begin
                chk(1'b0, "unexpected_word", out_word, -1);
            end else begin
                ew = exp_words.pop_front();
                chk(out_word == ew, "word", out_word, ew);
            end
            last_word = out_word;
        end
        if (out_eof) begin
            chk(exp_eof, "eof_expected", 1, exp_eof);
            chk(out_count == exp_len, "eof_count", out_count, exp_len);
            chk(!out_busy, "eof_busy", out_busy, 0);
            exp_eof = 1'b0;
            done = 1'b1;
            last_eof_cnt = out_count;
        end
        if (out_err) begin
            chk(exp_err, "err_expected", 1, exp_err);
            chk(!out_busy, "err_busy", out_busy, 0);
            exp_err = 1'b0;
            done = 1'b1;
            err_cyc = cyc;
        end
    end

    // Expected output streams for one frame, straight from the bit list.
    task automatic arm(input bit eb[$], input bit want_eof, input bit want_err);
        logic [DATA_W-1:0] w;
        exp_bits = eb;
        exp_words.delete();
        for (int i = 0; i + DATA_W <= eb.size(); i += DATA_W) begin
            w = '0;
            for (int j = 0; j < DATA_W; j++) w = {w[DATA_W-2:0], eb[i+j]};
            exp_words.push_back(w);
        end
        exp_len   = eb.size();
        exp_eof   = want_eof;
        exp_err   = want_err;
        model_cnt = 0;
        done      = 1'b0;
    endtask

    // Miller line edges for a bit list; cell start r is the sample offset of
    // the edge (real or virtual) that starts the cell.
    task automatic gen(input bit b[$], input bit jit, output int edges[$], output int len,
                       output bit eb[$]);
        int r;
        int db;
        int pick;
        int n;
        n = b.size();
        edges.delete();
        edges.push_back(0);
        r = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (b[i] == 1'b0 && b[i-1] == 1'b0) begin
                    if (force_db.size() > 0) begin
                        db = force_db.pop_front();
                    end else if (jit) begin
                        pick = $urandom_range(0, 3);
                        db = (pick == 0) ? CELL - 1 : (pick == 1) ? CELL :
                             (pick == 2) ? CELL + 2 : CELL + 3;
                    end else begin
                        db = CELL;
                    end
                    edges.push_back(r + db);
                    r += db;
                end else begin
                    r += CELL;
                end
            end
            if (b[i]) edges.push_back(r + (jit ? $urandom_range(HALF_BIT - 1, HALF_BIT + 2) : HALF_BIT));
        end
        len = r + 3 * CELL + 10;
        eb = b;
        // A trailing cell that carried an edge leaves one silent cell decoded as 0.
        if (!(b[n-1] == 1'b0 && (n == 1 || b[n-2] == 1'b1))) eb.push_back(1'b0);
    endtask

    task automatic check_cleared(input string name);
        chk(!out_valid,      {name, "_valid"},  out_valid, 0);
        chk(!out_word_valid, {name, "_wvalid"}, out_word_valid, 0);
        chk(!out_eof,        {name, "_eof"},    out_eof, 0);
        chk(!out_err,        {name, "_err"},    out_err, 0);
        chk(!out_busy,       {name, "_busy"},   out_busy, 0);
        chk(out_count == 0,  {name, "_count"},  out_count, 0);
        chk(out_word == 0,   {name, "_word"},   out_word, 0);
    endtask

    // abort_kind: 0 none, 1 rst pulse, 2 in_enable drop, at sample abort_t.
    task automatic drive(input int edges[$], input int len, input int abort_t, input int abort_kind);
        int k;
        k = 0;
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            in_enable = 1'b1;
            if (k < edges.size() && edges[k] == t) begin
                if (!(abort_kind != 0 && t > abort_t)) in_data = ~in_data;
                k++;
            end
            if (abort_kind != 0 && t == abort_t) begin
                if (abort_kind == 1) rst = 1'b1;
                else in_enable = 1'b0;
            end
            if (abort_kind != 0 && t == abort_t + 1) begin
                @(negedge clk);
                check_cleared(abort_kind == 1 ? "rst_abort" : "en_abort");
            end
        end
    endtask

    task automatic finish_frame(input bit want_done, input string name);
        int i;
        i = 0;
        while (!done && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (want_done) chk(done, {name, "_done"}, done, 1);
        repeat (40) @(negedge clk);
        chk(exp_bits.size() == 0, {name, "_bits_left"}, exp_bits.size(), 0);
        chk(exp_words.size() == 0, {name, "_words_left"}, exp_words.size(), 0);
        exp_eof = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic run_bits(input bit b[$], input bit jit, input string name);
        int e[$];
        int len;
        bit eb[$];
        gen(b, jit, e, len, eb);
        arm(eb, 1'b1, 1'b0);
        drive(e, len, -1, 0);
        finish_frame(1'b1, name);
    endtask

    task automatic run_violation(input int e[$], input bit eb[$], input string name);
        arm(eb, 1'b0, 1'b1);
        drive(e, 4 * CELL, -1, 0);
        finish_frame(1'b1, name);
    endtask

    initial begin
        bit b[$];
        bit eb[$];
        bit none[$];
        int e[$];
        int len;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Exact timing, known word.
        b = '{1, 0, 1, 1, 0, 0, 1, 0};
        run_bits(b, 1'b0, "exact");
        chk(last_word == 8'hB2, "exact_word_lit", last_word, 8'hB2);
        chk(last_eof_cnt == 8, "exact_count_lit", last_eof_cnt, 8);

        // Zero-pair boundaries at c=15, then c=1, then c=14.
        force_db = '{CELL, CELL + 2, CELL - 1};
        b = '{0, 0, 0, 1, 0, 0, 1, 1};
        run_bits(b, 1'b0, "drift");
        chk(last_word == 8'h13, "drift_word_lit", last_word, 8'h13);
        chk(last_eof_cnt == 9, "drift_count_lit", last_eof_cnt, 9);

        // Mid edge at c=11.
        e = '{0, HALF_BIT + 4};
        run_violation(e, none, "late_mid");

        // Boundary edge between 1 and 0: error at end of the 0 cell.
        e = '{0, HALF_BIT, CELL};
        eb = '{1};
        run_violation(e, eb, "bnd_1_0");
        chk(err_cyc - last_valid_cyc == CELL, "bnd_1_0_delay", err_cyc - last_valid_cyc, CELL);

        // Boundary edge in front of a 1.
        e = '{0, CELL, CELL + HALF_BIT};
        eb = '{0};
        run_violation(e, eb, "bnd_0_1");

        // Two mid edges in one cell.
        e = '{0, HALF_BIT, HALF_BIT + 2};
        run_violation(e, none, "double_mid");

        // Reset after five bits, then a fresh frame.
        b = '{1, 0, 1, 1, 0, 0, 1, 0};
        gen(b, 1'b0, e, len, eb);
        eb = '{1, 0, 1, 1, 0};
        arm(eb, 1'b0, 1'b0);
        drive(e, len, 88, 1);
        finish_frame(1'b0, "rst_abort");
        b = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
        run_bits(b, 1'b1, "after_rst");

        // One-cycle enable drop mid-word, then the first word must be intact.
        b = '{1, 0, 1, 1, 0, 0, 1, 0};
        gen(b, 1'b0, e, len, eb);
        eb = '{1, 0, 1, 1, 0};
        arm(eb, 1'b0, 1'b0);
        drive(e, len, 88, 2);
        finish_frame(1'b0, "en_abort");
        run_bits(b, 1'b0, "after_en");
        chk(last_word == 8'hB2, "after_en_word_lit", last_word, 8'hB2);

        // Random frames with in-tolerance jitter.
        for (int f = 0; f < 25; f++) begin
            b.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) b.push_back(1'($urandom_range(0, 1)));
            run_bits(b, 1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
